// File: rtl/tpo_sched_pkg.sv
// Shared types and widths for the TPO frame scheduler.
package tpo_sched_pkg;

    localparam int USER_W    = 2;
    localparam int SAMPLE_W  = 8;
    localparam int RESULT_W  = 15;
    localparam int NUM_USERS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tpo_sched_rr_arb3.sv
// Three-way round-robin arbiter. The search starts at the user after the
// pointer, so the most recently served user has the lowest priority.
module rr_arb3
    import tpo_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic              en,
    input  logic              upd,
    input  logic [USER_W-1:0] upd_idx,
    output logic [2:0]        gnt,
    output logic [USER_W-1:0] gnt_idx
);

    logic [USER_W-1:0] ptr;
    logic [USER_W-1:0] cand;
    logic              found;

    // Pick the first requester found when walking forward from ptr+1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (en) begin
            for (int i = 1; i <= NUM_USERS; i++) begin
                cand = USER_W'((int'(ptr) + i) % NUM_USERS);
                if (!found && req[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                    found     = 1'b1;
                end
            end
        end
    end

    // The pointer comes out of reset at the last user so that user 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= USER_W'(2);
        end else if (upd) begin
            ptr <= upd_idx;
        end
    end

endmodule

// File: rtl/tpo_sched.sv
// Shares one TPO engine between three sample requesters, one frame at a time.
// A frame is flushed into the engine, fed FRAME_LEN samples, and OUT_LEN
// results are captured into a user-tagged stream. The capture window is
// timed from the first accepted sample; results are sampled from tpo_out on
// the same edge that raises m_valid.
module tpo_sched
    import tpo_sched_pkg::*;
#(
    parameter int FRAME_LEN = 20,
    parameter int OUT_LEN   = 19,
    parameter int TPO_LAT   = 3
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 s_valid,
    input  logic [23:0]                s_data,
    output logic [2:0]                 s_ready,
    output logic                       tpo_rst,
    output logic                       tpo_en,
    output logic [SAMPLE_W-1:0]        tpo_din,
    output logic [USER_W-1:0]          tpo_mode,
    input  logic signed [RESULT_W-1:0] tpo_out,
    output logic                       m_valid,
    output logic                       m_last,
    output logic [USER_W-1:0]          m_user,
    output logic signed [RESULT_W-1:0] m_data,
    output logic                       busy,
    output logic                       err
);

    localparam int CAP_END = TPO_LAT + OUT_LEN;
    localparam int CNT_MAX = (FRAME_LEN > CAP_END) ? FRAME_LEN : CAP_END;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(TPO_LAT);
    localparam logic [CNT_W-1:0] CAP_STOP   = CNT_W'(CAP_END);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_END - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t              state;
    logic [USER_W-1:0]   grant_q;
    logic [CNT_W-1:0]    acc_cnt;
    logic [CNT_W-1:0]    cap_cnt;
    logic                cap_run;
    logic                cap_done;

    logic [2:0]          arb_gnt;
    logic [USER_W-1:0]   arb_idx;

    logic                sel_valid;
    logic [SAMPLE_W-1:0] sel_data;
    logic                accept;
    logic                cap_start;
    logic                cap_active;
    logic [CNT_W-1:0]    cap_cur;
    logic                cap_hit;
    logic                cap_last;

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (s_valid),
        .en      (state == ST_IDLE),
        .upd     (state == ST_DONE),
        .upd_idx (grant_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_valid = s_valid[grant_q];
    assign sel_data  = s_data[{grant_q, 3'b000} +: SAMPLE_W];
    assign accept    = (state == ST_FEED) && sel_valid;

    // Capture window position: counts cycles since the first accepted sample.
    always_comb begin
        cap_start  = accept && (acc_cnt == '0);
        cap_active = cap_run || cap_start;
        cap_cur    = cap_run ? cap_cnt : '0;
        cap_hit    = cap_active && (cap_cur >= CAP_FIRST) && (cap_cur < CAP_STOP);
        cap_last   = cap_active && (cap_cur == CAP_LAST);
    end

    // Frame sequencer with all interface outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_q  <= '0;
            acc_cnt  <= '0;
            cap_cnt  <= '0;
            cap_run  <= 1'b0;
            cap_done <= 1'b0;
            s_ready  <= '0;
            tpo_rst  <= 1'b1;
            tpo_en   <= 1'b0;
            tpo_din  <= '0;
            tpo_mode <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_user   <= '0;
            m_data   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            tpo_rst <= 1'b0;
            err     <= 1'b0;

            m_valid <= cap_hit;
            m_last  <= cap_last;
            if (cap_hit) begin
                m_data <= tpo_out;
                m_user <= grant_q;
            end
            if (cap_active) begin
                cap_cnt <= cap_cur + CNT_ONE;
                cap_run <= !cap_last;
                if (cap_last) begin
                    cap_done <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    tpo_en <= 1'b0;
                    if (|arb_gnt) begin
                        grant_q  <= arb_idx;
                        tpo_mode <= arb_idx;
                        tpo_rst  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    s_ready <= 3'b001 << grant_q;
                    state   <= ST_FEED;
                end
                ST_FEED: begin
                    if (sel_valid) begin
                        tpo_en  <= 1'b1;
                        tpo_din <= sel_data;
                        acc_cnt <= acc_cnt + CNT_ONE;
                        if (acc_cnt == FRAME_LAST) begin
                            s_ready <= '0;
                            state   <= ST_DRAIN;
                        end
                    end else begin
                        // Requester broke the frame: drop everything still in flight.
                        err     <= 1'b1;
                        tpo_en  <= 1'b0;
                        s_ready <= '0;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        cap_run <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    tpo_en <= 1'b0;
                    if (cap_done || cap_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    tpo_en   <= 1'b0;
                    busy     <= 1'b0;
                    acc_cnt  <= '0;
                    cap_cnt  <= '0;
                    cap_run  <= 1'b0;
                    cap_done <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tpo_sched.md
TPO_SCHED -- requirements
Module: tpo_sched

Interface
REQ-001 SHALL provide parameter FRAME_LEN, default 20, meaning input samples per frame fed to the TPO engine.
REQ-002 SHALL provide parameter OUT_LEN, default 19, meaning TPO result samples captured per frame.
REQ-003 SHALL provide parameter TPO_LAT, default 3, meaning cycles from the first tpo_en-high cycle to the first valid tpo_out.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port s_valid  input  3  per-requester frame-sample valid; bit k is user k.
REQ-007 SHALL have port s_data  input  24  packed 8-bit samples; user k occupies bits [8k+7:8k].
REQ-008 SHALL have port s_ready  output  3  per-requester accept; one-hot or zero.
REQ-009 SHALL have port tpo_rst  output  1  synchronous flush pulse to the TPO engine.
REQ-010 SHALL have port tpo_en  output  1  TPO sample enable.
REQ-011 SHALL have port tpo_din  output  8  TPO sample data.
REQ-012 SHALL have port tpo_mode  output  2  TPO mode; equals the granted user index.
REQ-013 SHALL have port tpo_out  input  15  signed TPO result.
REQ-014 SHALL have port m_valid, m_last, m_user[1:0], m_data[14:0] signed  output  result stream tagged with the user index.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE; err  output  1  one-cycle abort pulse.

Function
REQ-016 SHALL implement the states IDLE, FLUSH, FEED, DRAIN, DONE.
REQ-017 IDLE: when any s_valid bit is high, SHALL grant exactly one user round-robin, starting after the last granted user (after reset, priority order 0,1,2), latch the grant in grant_q, and go to FLUSH.
REQ-018 FLUSH: SHALL assert tpo_rst for exactly 1 cycle, drive tpo_mode=grant_q (held until DONE), and go to FEED.
REQ-019 FEED: s_ready[grant_q]=1; each cycle with s_valid[grant_q]=1 SHALL set tpo_en=1 and tpo_din=the sample; after FRAME_LEN accepts, SHALL go to DRAIN.
REQ-020 Requesters SHALL be required to hold s_valid for the whole frame; if s_valid[grant_q]=0 in FEED, SHALL pulse err, drop tpo_en, discard the frame (no further m_valid), and return to IDLE via FLUSH-less DONE.
REQ-021 The capture counter SHALL start on the first FEED accept; m_valid SHALL be high for OUT_LEN consecutive cycles beginning TPO_LAT cycles after that accept, with m_data=tpo_out registered 0 cycles (pass-through, registered output) and m_user=grant_q.
REQ-022 m_last SHALL be high only on the OUT_LEN-th m_valid cycle.
REQ-023 DRAIN: SHALL hold tpo_en=0 until m_last has been issued, then go to DONE; if the capture completes inside FEED, DRAIN lasts 1 cycle.
REQ-024 DONE: SHALL last 1 cycle, update the round-robin pointer to grant_q, and return to IDLE; the next grant is earliest the following cycle.
REQ-025 No back-pressure on the m_ interface; the downstream consumer SHALL always accept.
REQ-026 Requests arriving in non-IDLE states SHALL wait; s_ready for non-granted users SHALL stay 0.
REQ-027 Counters SHALL be sized ceil(log2(max(FRAME_LEN, TPO_LAT+OUT_LEN)+1)) bits and SHALL never wrap within a frame.

Reset
REQ-028 On rst=1, SHALL asynchronously go to IDLE with s_ready=0, tpo_en=0, tpo_rst=1, tpo_din=0, tpo_mode=0, m_valid=0, m_last=0, m_user=0, m_data=0, busy=0, err=0, and the round-robin pointer set to 2.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without an m_last or err.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the user-index width (2), the sample width (8), and the result width (15).
REQ-031 The round-robin arbiter SHALL be a sub-module rr_arb3 (3 requests, enable, one-hot grant, pointer update on DONE).

Verification
REQ-032 Single user 2: 20 samples of linear ramp on s_data[23:16] -> tpo_mode=2, tpo_rst pulses once, 20 tpo_en cycles, 19 m_valid with m_user=2, m_last on the 19th.
REQ-033 All three users request simultaneously after reset -> frames served in order 0,1,2, each preceded by a tpo_rst pulse, with no overlap of m_valid between users.
REQ-034 User 1 drops s_valid at sample 7 -> err pulses once, tpo_en low thereafter, no m_last, next request granted normally.
REQ-035 rst asserted at FEED sample 10 -> all outputs at reset values on the same cycle, busy=0, the next frame starts clean.
REQ-036 TPO_LAT=3 with a counting stub engine -> first m_valid exactly 3 cycles after the first tpo_en, last m_valid 21 cycles after it.
